// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic trigger/echo path.
// Distance thresholds are echo widths in clk cycles that bound the LED bands.
package ultrasonic_pkg;

  localparam int unsigned ECHO_W = 20;
  localparam int unsigned CNT_W  = 24;

  localparam int unsigned TRIG_MIN_DEF       = 500;
  localparam int unsigned BURST_DELAY_DEF    = 2000;
  localparam int unsigned HOLDOFF_DEF        = 3000;
  localparam int unsigned NO_ECHO_CYCLES_DEF = 1900000;
  localparam int unsigned SYNC_STAGES_DEF    = 2;

  localparam int unsigned DIST_FAR_CYC  = 70000;
  localparam int unsigned DIST_MID_CYC  = 45000;
  localparam int unsigned DIST_NEAR_CYC = 20000;
  localparam int unsigned DIST_MIN_CYC  = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HIGH,
    ST_DELAY,
    ST_ECHO,
    ST_HOLDOFF
  } state_e;

  // Terminal count for a phase lasting n cycles when the counter starts at 0.
  function automatic logic [CNT_W-1:0] last_cnt(input int unsigned n);
    return CNT_W'(n - 32'd1);
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Multi-flop synchronizer for the asynchronous trig pin, with a registered output.
module trig_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic trig_s_o
);

  logic [STAGES-1:0] sync_q;
  logic              trig_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      trig_s_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], trig_i};
      trig_s_q <= sync_q[STAGES-1];
    end
  end

  assign trig_s_o = trig_s_q;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style sensor emulator: qualifies a trigger pulse, waits a burst delay,
// then drives an echo pulse whose width is the programmed distance in cycles.
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_MIN       = TRIG_MIN_DEF,
  parameter int unsigned BURST_DELAY    = BURST_DELAY_DEF,
  parameter int unsigned HOLDOFF        = HOLDOFF_DEF,
  parameter int unsigned NO_ECHO_CYCLES = NO_ECHO_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              trig,
  input  logic [ECHO_W-1:0] echo_cycles,
  output logic              echo,
  output logic              busy,
  output logic              trig_err,
  output logic              done
);

  localparam logic [CNT_W-1:0] TRIG_MIN_C     = CNT_W'(TRIG_MIN);
  localparam logic [CNT_W-1:0] DELAY_LAST     = last_cnt(BURST_DELAY);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST   = last_cnt(HOLDOFF);
  localparam logic [CNT_W-1:0] NO_ECHO_LAST   = last_cnt(NO_ECHO_CYCLES);

  logic              trig_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ECHO_W-1:0] echo_len_q, echo_len_d;
  logic [CNT_W-1:0]  echo_last;
  logic              echo_q, busy_q, trig_err_q, done_q;
  logic              trig_err_d, done_d;

  trig_sync #(
    .STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig_i   (trig),
    .trig_s_o (trig_s)
  );

  // A zero programmed width means "no object": fall back to the timeout width.
  assign echo_last = (echo_len_q == '0) ? NO_ECHO_LAST
                                        : CNT_W'(echo_len_q) - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    echo_len_d = echo_len_q;
    trig_err_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable && trig_s) begin
          state_d = ST_TRIG_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_TRIG_HIGH: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (trig_s) begin
          cnt_d = (cnt_q >= TRIG_MIN_C) ? TRIG_MIN_C : cnt_q + CNT_W'(1);
        end else if (cnt_q >= TRIG_MIN_C) begin
          state_d    = ST_DELAY;
          cnt_d      = '0;
          echo_len_d = echo_cycles;
        end else begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          trig_err_d = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = ST_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ECHO: begin
        if (cnt_q == echo_last) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so echo tracks ECHO exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      echo_len_q <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_len_q <= echo_len_d;
      echo_q     <= (state_d == ST_ECHO);
      busy_q     <= (state_d != ST_IDLE);
      trig_err_q <= trig_err_d;
      done_q     <= done_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = trig_err_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for the echo responder, run with shortened timing parameters.
module tb_ultrasonic_echo_responder;

  localparam int unsigned TRIG_MIN   = 8;
  localparam int unsigned BURST      = 20;
  localparam int unsigned HOLD       = 30;
  localparam int unsigned NO_ECHO    = 100;
  localparam int unsigned SYNC       = 2;
  // Measured from the negedge where trig is lowered to the first negedge showing echo.
  localparam int LAT = 1 + SYNC + 1 + BURST;

  logic        clk = 1'b0;
  logic        rst_n, enable, trig;
  logic [19:0] echo_cycles;
  logic        echo, busy, trig_err, done;

  ultrasonic_echo_responder #(
    .TRIG_MIN       (TRIG_MIN),
    .BURST_DELAY    (BURST),
    .HOLDOFF        (HOLD),
    .NO_ECHO_CYCLES (NO_ECHO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .trig        (trig),
    .echo_cycles (echo_cycles),
    .echo        (echo),
    .busy        (busy),
    .trig_err    (trig_err),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int trig_len;
    int ec;
    int exp_err;
    int exp_width;
  } vec_t;

  int chk_n = 0;
  int pass_n = 0;
  int cyc = 0;
  int fall0 = 0;
  int echo_hi, rise_n, done_n, err_n, rise_cyc, bad_done, busy_seen;
  logic echo_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    chk_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_obs();
    echo_hi = 0; rise_n = 0; done_n = 0; err_n = 0;
    rise_cyc = 0; bad_done = 0; busy_seen = 0;
  endtask

  // One clock: sample outputs on the falling edge and accumulate observations.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (echo) echo_hi++;
    if (echo && !echo_prev) begin
      rise_n++;
      if (rise_n == 1) rise_cyc = cyc;
    end
    if (done) begin
      done_n++;
      if (!(echo_prev && !echo)) bad_done++;
    end
    if (trig_err) err_n++;
    if (busy) busy_seen++;
    echo_prev = echo;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk("busy_returns_idle", int'(busy), 0);
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!echo && n < 5000) begin
      tick();
      n++;
    end
    chk("echo_rise_seen", int'(echo), 1);
  endtask

  // Drive a trig pulse, then scramble echo_cycles once it must already be latched.
  task automatic run_trigger(input int trig_len, input int ec);
    clr_obs();
    echo_cycles = 20'(ec);
    trig = 1'b1;
    repeat (trig_len) tick();
    trig = 1'b0;
    fall0 = cyc;
    repeat (6) tick();
    echo_cycles = 20'h0ABCD;
    wait_idle();
    repeat (3) tick();
  endtask

  task automatic check_pulse(input int exp_err, input int exp_width);
    chk("trig_err_pulses", err_n, exp_err);
    chk("echo_width", echo_hi, exp_width);
    chk("done_pulses", done_n, (exp_width != 0) ? 1 : 0);
    chk("done_aligned_with_fall", bad_done, 0);
    if (exp_width != 0) chk("trig_to_echo_latency", rise_cyc - fall0, LAT);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{trig_len: 12, ec: 40,  exp_err: 0, exp_width: 40};
    vecs[1] = '{trig_len: 8,  ec: 5,   exp_err: 0, exp_width: 5};
    vecs[2] = '{trig_len: 7,  ec: 50,  exp_err: 1, exp_width: 0};
    vecs[3] = '{trig_len: 10, ec: 0,   exp_err: 0, exp_width: 100};
    vecs[4] = '{trig_len: 9,  ec: 1,   exp_err: 0, exp_width: 1};
    vecs[5] = '{trig_len: 3,  ec: 9,   exp_err: 1, exp_width: 0};
    vecs[6] = '{trig_len: 20, ec: 300, exp_err: 0, exp_width: 300};

    // Reset held with trig high: all outputs quiet, FSM waits for the synchronizer.
    rst_n = 1'b0; enable = 1'b1; trig = 1'b1; echo_cycles = 20'd25;
    clr_obs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_outputs_quiet", int'({echo, busy, trig_err, done}), 0);
    end
    rst_n = 1'b1;
    repeat (SYNC + 1) tick();
    chk("busy_low_during_sync", int'(busy), 0);
    tick();
    chk("busy_after_sync", int'(busy), 1);
    repeat (10) tick();
    clr_obs();
    trig = 1'b0;
    fall0 = cyc;
    wait_idle();
    check_pulse(0, 25);

    for (int i = 0; i < 7; i++) begin
      run_trigger(vecs[i].trig_len, vecs[i].ec);
      check_pulse(vecs[i].exp_err, vecs[i].exp_width);
    end

    // enable dropped in TRIG_HIGH aborts silently; disabled responder ignores trig.
    clr_obs();
    trig = 1'b1;
    repeat (6) tick();
    enable = 1'b0;
    repeat (6) tick();
    trig = 1'b0;
    repeat (8) tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_err", err_n, 0);
    chk("abort_no_echo", rise_n, 0);
    clr_obs();
    trig = 1'b1;
    repeat (12) tick();
    trig = 1'b0;
    repeat (8) tick();
    chk("disabled_never_busy", busy_seen, 0);
    enable = 1'b1;

    // Retriggers during ECHO and HOLDOFF are ignored.
    clr_obs();
    echo_cycles = 20'd60;
    trig = 1'b1;
    repeat (10) tick();
    trig = 1'b0;
    fall0 = cyc;
    wait_rise();
    repeat (5) tick();
    trig = 1'b1;
    repeat (12) tick();
    trig = 1'b0;
    begin
      int n = 0;
      while (echo && n < 5000) begin
        tick();
        n++;
      end
    end
    chk("echo_fell", int'(echo), 0);
    repeat (2) tick();
    trig = 1'b1;
    repeat (12) tick();
    trig = 1'b0;
    wait_idle();
    repeat (3) tick();
    check_pulse(0, 60);
    chk("single_echo_rise", rise_n, 1);
    run_trigger(10, 17);
    check_pulse(0, 17);

    // Reset asserted 100 cycles into ECHO kills the pulse without done.
    clr_obs();
    echo_cycles = 20'd200;
    trig = 1'b1;
    repeat (10) tick();
    trig = 1'b0;
    wait_rise();
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_echo_low", int'(echo), 0);
    chk("rst_busy_low", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", done_n, 0);
    run_trigger(10, 15);
    check_pulse(0, 15);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
